cg_memory_responder: RTL and testbench

- Memory-side endpoint of cg_memory_interface: implements the from_memory modport, answering read-address and write requests from a to_memory initiator (core fetch/LSU, DMA).
- Holds a word-addressed storage array, a fixed-latency read pipeline and a response buffer, so read data is never lost under rdata backpressure.
- Used as the bench/FPGA memory model and as the template for real SRAM wrappers.

---
 rtl/cg_memory_pkg.sv | 19 +
 rtl/cg_sync_fifo.sv | 60 ++++++
 rtl/cg_memory_responder.sv | 128 ++++++++++++
 tb/tb_cg_memory_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cg_memory_pkg.sv
// Shared helpers for the cg_memory responder: index sizing and parameter legality.
package cg_memory_pkg;

  localparam int MAX_READ_LATENCY = 4;

  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit latency_legal(input int read_latency, input int resp_depth);
    return (read_latency >= 1) && (read_latency <= MAX_READ_LATENCY) &&
           (resp_depth >= read_latency);
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/cg_sync_fifo.sv
// Synchronous FIFO with show-ahead head, full/empty flags and asynchronous reset.
module cg_sync_fifo
  import cg_memory_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = index_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage arrays carry no reset; only pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cg_memory_responder.sv
// Memory-side endpoint: word storage, fixed-latency read pipeline and an in-order response buffer.
module cg_memory_responder
  import cg_memory_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_LSB     = 2,
  parameter int READ_LATENCY = 1,
  parameter int RESP_DEPTH   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_raddr_valid,
  output logic                  o_raddr_ready,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic                  o_rdata_valid,
  input  logic                  i_rdata_ready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  input  logic                  i_wdata_valid,
  output logic                  o_wdata_ready,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata
);

  localparam int IDX_W = index_width(DEPTH);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  if (!latency_legal(READ_LATENCY, RESP_DEPTH)) begin : g_bad_latency
    $error("cg_memory_responder: READ_LATENCY must be 1..4 and <= RESP_DEPTH");
  end
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("cg_memory_responder: DEPTH must be a power of two >= 2");
  end

  logic                    run;
  logic [CNT_W-1:0]        count;
  logic                    rd_accept;
  logic                    wr_accept;
  logic                    rsp_hs;
  logic [IDX_W-1:0]        ridx;
  logic [IDX_W-1:0]        widx;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
  logic                    last_valid;
  logic [DATA_WIDTH-1:0]   last_data;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_WIDTH-1:0]   fifo_head;
  logic                    unused_addr_bits;

  // Handshake readiness is held low until the first edge after reset release.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) run <= 1'b0;
    else         run <= 1'b1;
  end

  assign o_wdata_ready = run;
  assign o_raddr_ready = run && (count < CNT_W'(RESP_DEPTH));
  assign rd_accept     = i_raddr_valid && o_raddr_ready;
  assign wr_accept     = i_wdata_valid && o_wdata_ready && i_wen;

  // Upper address bits alias onto the same words.
  assign ridx             = i_raddr[ADDR_LSB +: IDX_W];
  assign widx             = i_waddr[ADDR_LSB +: IDX_W];
  assign unused_addr_bits = ^{i_raddr, i_waddr};

  always_ff @(posedge i_clk) begin
    if (wr_accept) mem[widx] <= i_wdata;
  end

  // The array read shares the write edge, so a same-cycle read sees the old word.
  always_ff @(posedge i_clk) begin
    if (rd_accept) pipe_data[0] <= mem[ridx];
    for (int s = 1; s < READ_LATENCY; s++) pipe_data[s] <= pipe_data[s-1];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= rd_accept;
      for (int s = 1; s < READ_LATENCY; s++) pipe_valid[s] <= pipe_valid[s-1];
    end
  end

  assign last_valid = pipe_valid[READ_LATENCY-1];
  assign last_data  = pipe_data[READ_LATENCY-1];

  // The last pipeline stage bypasses an empty buffer; otherwise it queues behind older data.
  assign o_rdata_valid = !fifo_empty || last_valid;
  assign o_rdata       = !fifo_empty ? fifo_head : (last_valid ? last_data : '0);
  assign rsp_hs        = o_rdata_valid && i_rdata_ready;
  assign fifo_pop      = !fifo_empty && i_rdata_ready;
  assign fifo_push     = last_valid && !fifo_full && !(fifo_empty && i_rdata_ready);

  cg_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .push  (fifo_push),
    .wdata (last_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outstanding reads: pipeline plus buffer, bounded by RESP_DEPTH through o_raddr_ready.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count <= '0;
    end else begin
      case ({rd_accept, rsp_hs})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cg_memory_responder.sv
// Directed self-checking bench for cg_memory_responder (READ_LATENCY=1, RESP_DEPTH=2).
module tb_cg_memory_responder;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int RL    = 1;
  localparam int RD    = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          raddr_valid = 1'b0;
  logic          raddr_ready;
  logic [AW-1:0] raddr = '0;
  logic          rdata_valid;
  logic          rdata_ready = 1'b1;
  logic [DW-1:0] rdata;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic          wen = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cg_memory_responder #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH),
    .ADDR_LSB     (2),
    .READ_LATENCY (RL),
    .RESP_DEPTH   (RD)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_raddr_valid (raddr_valid),
    .o_raddr_ready (raddr_ready),
    .i_raddr       (raddr),
    .o_rdata_valid (rdata_valid),
    .i_rdata_ready (rdata_ready),
    .o_rdata       (rdata),
    .i_wdata_valid (wdata_valid),
    .o_wdata_ready (wdata_ready),
    .i_wen         (wen),
    .i_waddr       (waddr),
    .i_wdata       (wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
    n_checks++;
    if (got !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic en);
    wdata_valid = 1'b1;
    waddr       = addr;
    wdata       = data;
    wen         = en;
    step();
    wdata_valid = 1'b0;
    wen         = 1'b0;
  endtask

  // Issues one read with rdata_ready high and checks the response one cycle later.
  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    raddr_valid = 1'b1;
    raddr       = addr;
    step();
    raddr_valid = 1'b0;
    check({tag, "_valid"}, 32'(rdata_valid), 32'd1);
    check(tag, rdata, expected);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and idle
    #1 rstn = 1'b0;
    step();
    step();
    check("rst_raddr_ready", 32'(raddr_ready), 32'd0);
    check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check("rst_rdata",       rdata,            32'd0);
    check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    rstn = 1'b1;
    step();
    check("idle_wdata_ready", 32'(wdata_ready), 32'd1);
    check("idle_raddr_ready", 32'(raddr_ready), 32'd1);
    check("idle_rdata_valid", 32'(rdata_valid), 32'd0);

    // Write then read with exact latency
    write_word(32'h10, 32'hDEADBEEF, 1'b1);
    raddr_valid = 1'b1;
    raddr       = 32'h10;
    check("lat_pre_valid", 32'(rdata_valid), 32'd0);
    step();
    raddr_valid = 1'b0;
    for (int i = 1; i < RL; i++) begin
      check("lat_early_valid", 32'(rdata_valid), 32'd0);
      step();
    end
    check("lat_valid", 32'(rdata_valid), 32'd1);
    check("lat_data",  rdata,            32'hDEADBEEF);
    step();
    check("lat_drained", 32'(rdata_valid), 32'd0);

    // Same-cycle read and write to one index: old data first
    write_word(32'h20, 32'h1, 1'b1);
    wdata_valid = 1'b1; wen = 1'b1; waddr = 32'h20; wdata = 32'h2;
    raddr_valid = 1'b1; raddr = 32'h20;
    step();
    wdata_valid = 1'b0; wen = 1'b0; raddr_valid = 1'b0;
    check("rbw_old", rdata, 32'h1);
    step();
    read_check("rbw_new", 32'h20, 32'h2);

    // Backpressure: two reads fill the responder, third stalls
    write_word(32'h40, 32'hA0, 1'b1);
    write_word(32'h44, 32'hA1, 1'b1);
    write_word(32'h48, 32'hA2, 1'b1);
    rdata_ready = 1'b0;
    raddr_valid = 1'b1; raddr = 32'h40;
    check("bp_ready0", 32'(raddr_ready), 32'd1);
    step();
    raddr = 32'h44;
    check("bp_ready1", 32'(raddr_ready), 32'd1);
    step();
    raddr = 32'h48;
    check("bp_stall", 32'(raddr_ready), 32'd0);
    check("bp_head",  rdata,            32'hA0);
    step();
    check("bp_stall_hold", 32'(raddr_ready), 32'd0);
    check("bp_hold_valid", 32'(rdata_valid), 32'd1);
    check("bp_hold_data",  rdata,            32'hA0);
    rdata_ready = 1'b1;
    step();
    check("bp_second",     rdata,            32'hA1);
    check("bp_ready_back", 32'(raddr_ready), 32'd1);
    step();
    raddr_valid = 1'b0;
    check("bp_third_valid", 32'(rdata_valid), 32'd1);
    check("bp_third",       rdata,            32'hA2);
    step();
    check("bp_empty", 32'(rdata_valid), 32'd0);

    // Back-to-back reads, one response per cycle
    for (int i = 0; i < 4; i++) write_word(32'(i * 4), 32'h100 + 32'(i), 1'b1);
    for (int i = 0; i < 4; i++) begin
      raddr_valid = 1'b1;
      raddr       = 32'(i * 4);
      check("b2b_ready", 32'(raddr_ready), 32'd1);
      step();
      check("b2b_valid", 32'(rdata_valid), 32'd1);
      check("b2b_data",  rdata,            32'h100 + 32'(i));
    end
    raddr_valid = 1'b0;
    step();
    check("b2b_drained", 32'(rdata_valid), 32'd0);

    // Index wrap: DEPTH<<2 aliases word 0
    write_word(32'(DEPTH << 2), 32'h77, 1'b1);
    read_check("wrap", 32'h0, 32'h77);

    // Write handshake with wen low leaves storage alone
    write_word(32'h10, 32'h12345678, 1'b0);
    read_check("wen_low", 32'h10, 32'hDEADBEEF);

    // Reset with two reads outstanding
    rdata_ready = 1'b0;
    raddr_valid = 1'b1; raddr = 32'h10;
    step();
    raddr = 32'h20;
    step();
    raddr_valid = 1'b0;
    check("mid_pre_valid", 32'(rdata_valid), 32'd1);
    check("mid_pre_ready", 32'(raddr_ready), 32'd0);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid",  32'(rdata_valid), 32'd0);
    check("mid_rst_rdata",  rdata,            32'd0);
    check("mid_rst_rready", 32'(raddr_ready), 32'd0);
    check("mid_rst_wready", 32'(wdata_ready), 32'd0);
    step();
    rstn        = 1'b1;
    rdata_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_no_stale", 32'(rdata_valid), 32'd0);
    end
    check("mid_ready_back", 32'(raddr_ready), 32'd1);
    read_check("mid_after", 32'h20, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
